// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: PC hand-off, instruction-memory request/response and decode delivery.
// The fetch unit takes the master side; memory, PC and decode models take the slave side.
interface instr_fetch_unit_if;
    logic        pc_advance;
    logic [31:0] pc_in;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        flush;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    modport master (
        input  pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data, flush, inst_ready,
        output pc_advance, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data, flush, inst_ready,
        input  pc_advance, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Credit-limited instruction fetch: issues in-order memory requests, pairs responses with
// their addresses, buffers them for decode, and drops stale responses after a redirect.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master ifu
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SUM_W-1:0] CREDITS = SUM_W'(DEPTH);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] buffered_q, buffered_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    // Queues hold DEPTH entries; pointers wrap naturally because DEPTH is a power of two.
    logic [PTR_W-1:0]        aq_wr_q, aq_rd_q;
    logic [PTR_W-1:0]        ib_wr_q, ib_rd_q;
    logic [DEPTH-1:0][31:0]  aq_addr_q;
    logic [DEPTH-1:0][31:0]  ib_pc_q;
    logic [DEPTH-1:0][31:0]  ib_data_q;

    logic credit_ok;
    logic req_valid;
    logic req_fire;
    logic rsp_hit;
    logic rsp_keep;
    logic rsp_drop;
    logic inst_avail;
    logic inst_fire;

    // Credits count both outstanding requests and undelivered instructions, pre-edge.
    assign credit_ok  = ({1'b0, inflight_q} + {1'b0, buffered_q}) < CREDITS;
    assign req_valid  = (state_q == ST_RUN) && !ifu.flush && credit_ok;
    assign req_fire   = req_valid && ifu.imem_req_ready;
    assign rsp_hit    = ifu.imem_rsp_valid && (inflight_q != '0);
    assign rsp_drop   = rsp_hit && (discard_q != '0);
    assign rsp_keep   = rsp_hit && (discard_q == '0);
    assign inst_avail = (buffered_q != '0);
    assign inst_fire  = inst_avail && !ifu.flush && ifu.inst_ready;

    assign ifu.imem_req_valid = req_valid;
    assign ifu.imem_req_addr  = ifu.pc_in;
    assign ifu.pc_advance     = req_fire;
    assign ifu.inst_valid     = inst_avail && !ifu.flush;
    assign ifu.inst_data      = inst_avail ? ib_data_q[ib_rd_q] : '0;
    assign ifu.inst_pc        = inst_avail ? ib_pc_q[ib_rd_q]   : '0;

    always_comb begin
        state_d    = state_q;
        inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_hit);
        discard_d  = discard_q - CNT_W'(rsp_drop);
        buffered_d = buffered_q + CNT_W'(rsp_keep) - CNT_W'(inst_fire);

        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            ST_DRAIN: if (discard_d == '0) state_d = ST_RUN;
            default:  state_d = ST_BOOT;
        endcase

        // A response landing with the flush is already stale, so it leaves the discard count.
        if (ifu.flush) begin
            discard_d  = inflight_d;
            buffered_d = '0;
            state_d    = (inflight_d != '0) ? ST_DRAIN : ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            inflight_q <= '0;
            buffered_q <= '0;
            discard_q  <= '0;
            aq_wr_q    <= '0;
            aq_rd_q    <= '0;
            ib_wr_q    <= '0;
            ib_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            buffered_q <= buffered_d;
            discard_q  <= discard_d;
            if (ifu.flush) begin
                aq_wr_q <= '0;
                aq_rd_q <= '0;
                ib_wr_q <= '0;
                ib_rd_q <= '0;
            end else begin
                if (req_fire) aq_wr_q <= aq_wr_q + PTR_W'(1);
                if (rsp_keep) begin
                    aq_rd_q <= aq_rd_q + PTR_W'(1);
                    ib_wr_q <= ib_wr_q + PTR_W'(1);
                end
                if (inst_fire) ib_rd_q <= ib_rd_q + PTR_W'(1);
            end
        end
    end

    // Payload storage needs no reset: occupancy counters gate every read.
    always_ff @(posedge clk) begin
        if (req_fire) aq_addr_q[aq_wr_q] <= ifu.pc_in;
        if (rsp_keep) begin
            ib_pc_q[ib_wr_q]   <= aq_addr_q[aq_rd_q];
            ib_data_q[ib_wr_q] <= ifu.imem_rsp_data;
        end
    end

    // Upstream PC must present the boot vector while the unit leaves BOOT.
    always @(posedge clk) begin
        if (!rst && state_q == ST_BOOT) assert (ifu.pc_in == RESET_PC);
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot, streaming, backpressure, flush/drain and async reset.
module tb_instr_fetch_unit;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    instr_fetch_unit_if ifu ();

    instr_fetch_unit #(.RESET_PC(32'h0100_0000), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .ifu (ifu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_io(input string tag, input logic rv, input logic adv, input logic iv);
        chk({tag, ".req_valid"},  {31'd0, ifu.imem_req_valid}, {31'd0, rv});
        chk({tag, ".pc_advance"}, {31'd0, ifu.pc_advance},     {31'd0, adv});
        chk({tag, ".inst_valid"}, {31'd0, ifu.inst_valid},     {31'd0, iv});
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] pc, input logic [31:0] data);
        chk({tag, ".inst_pc"},   ifu.inst_pc,   pc);
        chk({tag, ".inst_data"}, ifu.inst_data, data);
    endtask

    // Drive one cycle's inputs, then let combinational outputs settle.
    task automatic drv(input logic [31:0] pc, input logic rv, input logic [31:0] rd,
                       input logic fl, input logic ir, input logic rdy);
        ifu.pc_in          = pc;
        ifu.imem_rsp_valid = rv;
        ifu.imem_rsp_data  = rd;
        ifu.flush          = fl;
        ifu.inst_ready     = ir;
        ifu.imem_req_ready = rdy;
        #1;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        ifu.pc_in = '0; ifu.imem_req_ready = 1'b0; ifu.imem_rsp_valid = 1'b0;
        ifu.imem_rsp_data = '0; ifu.flush = 1'b0; ifu.inst_ready = 1'b0;
        #3;
        chk_io("reset", 0, 0, 0);
        chk_inst("reset", 32'h0, 32'h0);
        nxt; nxt;
        rst = 1'b0;

        // BOOT cycle issues nothing; first request follows.
        drv(32'h0100_0000, 0, 32'h0, 0, 1, 1); chk_io("boot", 0, 0, 0);
        nxt; drv(32'h0100_0000, 0, 32'h0, 0, 1, 1); chk_io("req0", 1, 1, 0);
        chk("req0.addr", ifu.imem_req_addr, 32'h0100_0000);
        nxt; drv(32'h0100_0004, 1, 32'h1111_0000, 0, 1, 1); chk_io("req1", 1, 1, 0);
        chk("req1.addr", ifu.imem_req_addr, 32'h0100_0004);
        nxt; drv(32'h0100_0008, 1, 32'h2222_0004, 0, 1, 1); chk_io("credit_full", 0, 0, 1);
        chk_inst("i0", 32'h0100_0000, 32'h1111_0000);
        nxt; drv(32'h0100_0008, 0, 32'h0, 0, 1, 1); chk_io("req2", 1, 1, 1);
        chk_inst("i1", 32'h0100_0004, 32'h2222_0004);
        chk("req2.addr", ifu.imem_req_addr, 32'h0100_0008);
        nxt; drv(32'h0100_000C, 1, 32'h3333_0008, 0, 1, 1); chk_io("req3", 1, 1, 0);
        nxt; drv(32'h0100_0010, 1, 32'h4444_000C, 0, 1, 1); chk_io("s7", 0, 0, 1);
        chk_inst("i2", 32'h0100_0008, 32'h3333_0008);

        // Decode stalls: credits run out and issue stops until a pop.
        nxt; drv(32'h0100_0010, 0, 32'h0, 0, 0, 1); chk_io("bp0", 1, 1, 1);
        chk_inst("bp0", 32'h0100_000C, 32'h4444_000C);
        nxt; drv(32'h0100_0014, 1, 32'h5555_0010, 0, 0, 1); chk_io("bp1", 0, 0, 1);
        nxt; drv(32'h0100_0014, 0, 32'h0, 0, 0, 1); chk_io("bp2", 0, 0, 1);
        chk_inst("bp2", 32'h0100_000C, 32'h4444_000C);
        nxt; drv(32'h0100_0014, 0, 32'h0, 0, 1, 1); chk_io("pop", 0, 0, 1);
        nxt; drv(32'h0100_0014, 0, 32'h0, 0, 0, 1); chk_io("resume", 1, 1, 1);
        chk("resume.addr", ifu.imem_req_addr, 32'h0100_0014);
        chk_inst("i4", 32'h0100_0010, 32'h5555_0010);

        // Two in flight, then flush into DRAIN.
        nxt; drv(32'h0100_0018, 0, 32'h0, 0, 1, 1); chk_io("s13", 0, 0, 1);
        nxt; drv(32'h0100_0018, 0, 32'h0, 0, 1, 1); chk_io("s14", 1, 1, 0);
        nxt; drv(32'h0100_001C, 0, 32'h0, 0, 1, 1); chk_io("two_inflight", 0, 0, 0);
        nxt; drv(32'h0100_001C, 0, 32'h0, 1, 1, 1); chk_io("flush", 0, 0, 0);
        nxt; drv(32'h0200_0000, 1, 32'hDEAD_BEEF, 0, 1, 1); chk_io("drain1", 0, 0, 0);
        nxt; drv(32'h0200_0000, 1, 32'hDEAD_BEEF, 0, 1, 1); chk_io("drain2", 0, 0, 0);
        nxt; drv(32'h0200_0000, 0, 32'h0, 0, 1, 1); chk_io("post_drain", 1, 1, 0);
        chk("post_drain.addr", ifu.imem_req_addr, 32'h0200_0000);
        nxt; drv(32'h0200_0004, 1, 32'h6666_0000, 0, 1, 1); chk_io("s20", 1, 1, 0);
        nxt; drv(32'h0200_0008, 0, 32'h0, 0, 1, 1); chk_io("s21", 0, 0, 1);
        chk_inst("redirect", 32'h0200_0000, 32'h6666_0000);

        // Flush coincident with a response and a ready decode.
        nxt; drv(32'h0200_0008, 1, 32'h7777_0004, 0, 1, 1); chk_io("s22", 1, 1, 0);
        nxt; drv(32'h0200_000C, 1, 32'h8888_0008, 1, 1, 1); chk_io("flush_rsp", 0, 0, 0);
        nxt; drv(32'h0300_0000, 0, 32'h0, 0, 1, 1); chk_io("after_flush", 1, 1, 0);
        chk("after_flush.addr", ifu.imem_req_addr, 32'h0300_0000);
        nxt; drv(32'h0300_0004, 1, 32'h9999_0000, 0, 1, 1); chk_io("s25", 1, 1, 0);
        nxt; drv(32'h0300_0008, 0, 32'h0, 0, 1, 1); chk_io("s26", 0, 0, 1);
        chk_inst("no_stale", 32'h0300_0000, 32'h9999_0000);

        // Async reset pulse between edges with two requests outstanding.
        nxt; drv(32'h0300_0008, 0, 32'h0, 0, 1, 1); chk_io("s27", 1, 1, 0);
        nxt; drv(32'h0300_000C, 0, 32'h0, 0, 1, 1); chk_io("s28", 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk_io("async_rst", 0, 0, 0);
        chk_inst("async_rst", 32'h0, 32'h0);
        #1 rst = 1'b0;
        drv(32'h0100_0000, 1, 32'hDEAD_BEEF, 0, 1, 1); chk_io("boot2", 0, 0, 0);
        nxt; drv(32'h0100_0000, 1, 32'hDEAD_BEEF, 0, 1, 1); chk_io("boot2_req", 1, 1, 0);
        chk("boot2.addr", ifu.imem_req_addr, 32'h0100_0000);
        nxt; drv(32'h0100_0004, 0, 32'h0, 0, 1, 0); chk_io("late_ignored", 1, 0, 0);
        nxt; drv(32'h0100_0004, 1, 32'hAAAA_0000, 0, 1, 0); chk_io("r4", 1, 0, 0);
        nxt; drv(32'h0100_0004, 0, 32'h0, 0, 1, 0); chk_io("r5", 1, 0, 1);
        chk_inst("boot2_inst", 32'h0100_0000, 32'hAAAA_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
